// File: rtl/mem_req_pkg.sv
// Shared types and constants for the decode-to-execute memory request path.
package mem_req_pkg;

    localparam int unsigned MEM_AW     = 20;
    localparam int unsigned REQ_CTRL_W = 3;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic              rw;
        logic              ena;
        logic              ipw;
    } mem_req_t;

endpackage

// File: rtl/mem_req_stage.sv
// One elastic pipeline slot: a valid bit plus payload register with load/hold and flush.
module mem_req_stage #(
    parameter int unsigned W = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic         up_valid_i,
    input  logic [W-1:0] up_data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Payload only moves with a valid request so a bubble never clobbers it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_req_pipe.sv
// Elastic DEPTH-stage memory request pipe with backpressure, flush,
// occupancy tracking and an in-flight store-address hazard check.
module mem_req_pipe
    import mem_req_pkg::*;
#(
    parameter int unsigned AW    = MEM_AW,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic          in_rw,
    input  logic          in_ena,
    input  logic          in_ipw,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic          out_rw,
    output logic          out_ena,
    output logic          out_ipw,
    input  logic [AW-1:0] chk_addr,
    output logic          chk_hit,
    output logic [CW-1:0] occupancy
);

    localparam int unsigned PW = AW + REQ_CTRL_W;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          rw;
        logic          ena;
        logic          ipw;
    } req_t;

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [PW-1:0]    p [DEPTH];
    logic [PW-1:0]    in_req;
    req_t             out_req;

    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    occ_q, occ_d;
    logic             hit;

    assign in_req = {in_addr, in_rw, in_ena, in_ipw};

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic          up_v;
        logic [PW-1:0] up_p;

        if (g == 0) begin : g_head
            assign up_v = in_valid;
            assign up_p = in_req;
        end else begin : g_body
            assign up_v = v[g-1];
            assign up_p = p[g-1];
        end

        mem_req_stage #(
            .W (PW)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush_i    (flush),
            .load_i     (rdy[g]),
            .up_valid_i (up_v),
            .up_data_i  (up_p),
            .valid_o    (v[g]),
            .data_o     (p[g])
        );
    end

    // Ready ripples back from the consumer; an empty slot absorbs a stall.
    always_comb begin
        rdy            = '0;
        rdy[DEPTH-1]   = !v[DEPTH-1] || out_ready;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            rdy[DEPTH-1-k] = !v[DEPTH-1-k] || rdy[DEPTH-k];
        end
    end

    assign in_ready = rdy[0] && !flush;

    assign out_req   = req_t'(p[DEPTH-1]);
    assign out_valid = v[DEPTH-1];
    assign out_addr  = out_req.addr;
    assign out_rw    = out_req.rw;
    assign out_ena   = out_req.ena;
    assign out_ipw   = out_req.ipw;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = v[DEPTH-1] && out_ready;

    always_comb begin
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

    always_comb begin
        req_t r;
        r   = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            r = req_t'(p[i]);
            if (v[i] && (r.rw == RW_WRITE) && r.ena && (r.addr == chk_addr)) begin
                hit = 1'b1;
            end
        end
    end

    assign chk_hit = hit;

endmodule

// File: tb/tb_mem_req_pipe.sv
// Scoreboard bench for mem_req_pipe at DEPTH=2.
module tb_mem_req_pipe;
    import mem_req_pkg::*;

    localparam int unsigned AW    = MEM_AW;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic          in_rw;
    logic          in_ena;
    logic          in_ipw;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic          out_rw;
    logic          out_ena;
    logic          out_ipw;
    logic [AW-1:0] chk_addr;
    logic          chk_hit;
    logic [CW-1:0] occupancy;

    mem_req_pipe #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_rw     (in_rw),
        .in_ena    (in_ena),
        .in_ipw    (in_ipw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_rw    (out_rw),
        .out_ena   (out_ena),
        .out_ipw   (out_ipw),
        .chk_addr  (chk_addr),
        .chk_hit   (chk_hit),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    mem_req_t q[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    int       n_out    = 0;
    logic     last_ov;
    int       last_occ;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    task automatic set_in(input logic v, input logic [AW-1:0] a, input logic rw,
                          input logic ena, input logic ipw);
        in_valid = v;
        in_addr  = a;
        in_rw    = rw;
        in_ena   = ena;
        in_ipw   = ipw;
    endtask

    // One clock: check handshake/occupancy/hazard against the queue model, retire and accept.
    task automatic cycle();
        logic     exp_ready;
        logic     exp_hit;
        mem_req_t cur;
        logic     do_push;
        #1;
        exp_ready = !flush && ((q.size() < DEPTH) || out_ready);
        exp_hit   = 1'b0;
        foreach (q[j]) begin
            if (q[j].rw == RW_WRITE && q[j].ena && q[j].addr == chk_addr) exp_hit = 1'b1;
        end
        last_ov  = out_valid;
        last_occ = int'(occupancy);

        n_checks++;
        if (in_ready !== exp_ready) $display("FAIL in_ready: got %b need %b", in_ready, exp_ready);
        else n_pass++;
        n_checks++;
        if ($isunknown(occupancy) || int'(occupancy) != q.size())
            $display("FAIL occupancy: got %0d need %0d", occupancy, q.size());
        else n_pass++;
        n_checks++;
        if (chk_hit !== exp_hit) $display("FAIL chk_hit: got %b need %b (chk_addr %h)", chk_hit, exp_hit, chk_addr);
        else n_pass++;

        cur     = '{addr: in_addr, rw: in_rw, ena: in_ena, ipw: in_ipw};
        do_push = in_valid && exp_ready;

        if (out_valid === 1'b1 && out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL out_extra: got request %h with nothing expected", {out_addr, out_rw, out_ena, out_ipw});
            end else begin
                if ({out_addr, out_rw, out_ena, out_ipw} !== q[0])
                    $display("FAIL out_payload: got %h need %h", {out_addr, out_rw, out_ena, out_ipw}, q[0]);
                else n_pass++;
                void'(q.pop_front());
            end
            n_out++;
        end
        if (flush) q.delete();
        else if (do_push) q.push_back(cur);

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        flush     = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, '0, RW_READ, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (q.size() == 0) break;
            cycle();
        end
        #1;
        n_checks++;
        if (q.size() != 0 || out_valid !== 1'b0 || occupancy !== '0)
            $display("FAIL drain: got %0d pending, out_valid %b, occupancy %0d; need 0/0/0", q.size(), out_valid, occupancy);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_addr !== '0 || occupancy !== '0 || in_ready !== 1'b1 || chk_hit !== 1'b0)
            $display("FAIL reset_init: got ov %b addr %h occ %0d ir %b hit %b need 0 0 0 1 0",
                     out_valid, out_addr, occupancy, in_ready, chk_hit);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;

        out_ready = 1'b0;
        chk_addr  = 20'h00111;
        set_in(1'b1, 20'h00111, RW_WRITE, 1'b1, 1'b1);
        cycle();
        set_in(1'b1, 20'h00112, RW_WRITE, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, '0, RW_READ, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_addr !== '0 || out_rw !== 1'b0 || out_ena !== 1'b0 || out_ipw !== 1'b0)
            $display("FAIL reset_mid_out: got ov %b payload %h need 0 0", out_valid, {out_addr, out_rw, out_ena, out_ipw});
        else n_pass++;
        n_checks++;
        if (occupancy !== '0 || in_ready !== 1'b1 || chk_hit !== 1'b0)
            $display("FAIL reset_mid_ctl: got occ %0d ir %b hit %b need 0 1 0", occupancy, in_ready, chk_hit);
        else n_pass++;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk_addr = '0;
    endtask

    task automatic test_stream();
        logic [5:0]    ov_pat;
        int            peak;
        int            out0;
        logic [AW-1:0] a;
        ov_pat    = '0;
        peak      = 0;
        out0      = n_out;
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            a = 20'h00010 + AW'(j);
            if (j < 3) set_in(1'b1, a, RW_READ, 1'b1, 1'b0);
            else       set_in(1'b0, '0, RW_READ, 1'b0, 1'b0);
            cycle();
            ov_pat[j] = last_ov;
            if (last_occ > peak) peak = last_occ;
        end
        n_checks++;
        if (ov_pat !== 6'b011100) $display("FAIL stream_timing: got out_valid pattern %b need 011100", ov_pat);
        else n_pass++;
        n_checks++;
        if (peak != 2) $display("FAIL stream_peak: got %0d need 2", peak);
        else n_pass++;
        n_checks++;
        if (n_out - out0 != 3) $display("FAIL stream_count: got %0d need 3", n_out - out0);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int out0;
        out0      = n_out;
        out_ready = 1'b0;
        set_in(1'b1, 20'h0A000, RW_WRITE, 1'b1, 1'b0);
        cycle();
        set_in(1'b1, 20'h0A004, RW_READ, 1'b1, 1'b1);
        cycle();
        set_in(1'b1, 20'h0A008, RW_WRITE, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_addr !== 20'h0A000 || out_rw !== RW_WRITE || occupancy !== 2'd2)
                $display("FAIL bp_hold: got ir %b ov %b addr %h rw %b occ %0d need 0 1 0a000 1 2",
                         in_ready, out_valid, out_addr, out_rw, occupancy);
            else n_pass++;
            cycle();
        end
        drain();
        n_checks++;
        if (n_out - out0 != 2) $display("FAIL bp_count: got %0d need 2", n_out - out0);
        else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(1'b1, 20'h0B000, RW_WRITE, 1'b1, 1'b0);
        cycle();
        set_in(1'b1, 20'h0B001, RW_READ, 1'b1, 1'b0);
        cycle();
        set_in(1'b1, 20'h0B002, RW_WRITE, 1'b1, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        set_in(1'b0, '0, RW_READ, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== '0 || out_addr !== 20'h0B000)
            $display("FAIL flush_state: got ov %b occ %0d addr %h need 0 0 0b000", out_valid, occupancy, out_addr);
        else n_pass++;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) cycle();

        // flush together with an output take: the take still retires
        out_ready = 1'b0;
        set_in(1'b1, 20'h0B010, RW_READ, 1'b0, 1'b1);
        cycle();
        set_in(1'b1, 20'h0B011, RW_READ, 1'b1, 1'b0);
        cycle();
        out_ready = 1'b1;
        flush     = 1'b1;
        cycle();
        flush = 1'b0;
        drain();
    endtask

    task automatic test_hazard();
        out_ready = 1'b0;
        chk_addr  = 20'h12345;
        set_in(1'b1, 20'h12345, RW_WRITE, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, '0, RW_READ, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (chk_hit !== 1'b1) $display("FAIL hazard_hit: got %b need 1", chk_hit);
        else n_pass++;
        chk_addr = 20'h12344;
        #1;
        n_checks++;
        if (chk_hit !== 1'b0) $display("FAIL hazard_addr_miss: got %b need 0", chk_hit);
        else n_pass++;
        chk_addr = 20'h12345;
        @(negedge clk);
        drain();
        #1;
        n_checks++;
        if (chk_hit !== 1'b0) $display("FAIL hazard_drained: got %b need 0", chk_hit);
        else n_pass++;
        @(negedge clk);

        out_ready = 1'b0;
        set_in(1'b1, 20'h12345, RW_READ, 1'b1, 1'b0);
        cycle();
        set_in(1'b1, 20'h12345, RW_WRITE, 1'b0, 1'b1);
        cycle();
        set_in(1'b0, '0, RW_READ, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (chk_hit !== 1'b0) $display("FAIL hazard_read_or_disabled: got %b need 0", chk_hit);
        else n_pass++;
        @(negedge clk);
        drain();
        chk_addr = '0;
    endtask

    task automatic test_back_to_back();
        int out0;
        out_ready = 1'b0;
        set_in(1'b1, 20'h0C000, RW_WRITE, 1'b1, 1'b0);
        cycle();
        set_in(1'b1, 20'h0C001, RW_READ, 1'b1, 1'b1);
        cycle();
        out_ready = 1'b1;
        out0      = n_out;
        for (int j = 0; j < 10; j++) begin
            set_in(1'b1, 20'h0C002 + AW'(j), j[0], 1'b1, j[1]);
            #1;
            n_checks++;
            if (in_ready !== 1'b1 || occupancy !== 2'd2 || out_valid !== 1'b1)
                $display("FAIL passthru: got ir %b occ %0d ov %b need 1 2 1", in_ready, occupancy, out_valid);
            else n_pass++;
            cycle();
        end
        n_checks++;
        if (n_out - out0 != 10) $display("FAIL passthru_count: got %0d need 10", n_out - out0);
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int j = 0; j < 120; j++) begin
            a = 20'h0D000 + AW'($urandom_range(0, 3));
            set_in(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk_addr  = 20'h0D000 + AW'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            cycle();
        end
        drain();
        chk_addr = '0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        chk_addr  = '0;
        set_in(1'b0, '0, RW_READ, 1'b0, 1'b0);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_hazard();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_req_pipe.md
Name: mem_req_pipe

Overview:
- Parametrised elastic pipeline that carries a memory request (address, read/write, enable, IP-write) from decode to execute/memory.
- Generalises the fixed single-register ID/EX request latch to DEPTH stages with a valid/ready handshake, backpressure, synchronous flush, occupancy tracking and an in-flight store-address hazard check.
- Sits between the decode stage (request producer) and the data-memory/IP interface (consumer).

Parameters:
- AW, 20, request address width in bits.
- DEPTH, 2, number of register stages (>=1); unstalled latency in cycles.
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous pipeline kill; highest priority.
- in_valid  in  1  producer presents a request.
- in_ready  out  1  pipe accepts the request this cycle.
- in_addr  in  AW  request address.
- in_rw  in  1  1 = write, 0 = read.
- in_ena  in  1  data-memory enable.
- in_ipw  in  1  IP write strobe.
- out_valid  out  1  stage DEPTH-1 holds a request.
- out_ready  in  1  consumer takes the request.
- out_addr  out  AW  payload of the last stage.
- out_rw  out  1  payload of the last stage.
- out_ena  out  1  payload of the last stage.
- out_ipw  out  1  payload of the last stage.
- chk_addr  in  AW  address to test against in-flight stores.
- chk_hit  out  1  an in-flight valid write matches chk_addr.
- occupancy  out  CW  number of valid stages.

Behaviour:
- Reset: all stage valid bits = 0; all payload registers = 0; occupancy = 0. As a result, out_valid = 0, out_addr/out_rw/out_ena/out_ipw = 0 and chk_hit = 0. in_ready = 1 after reset.
- Stage i state: v[i] plus payload p[i] = {addr, rw, ena, ipw}. Stage 0 is the input side; stage DEPTH-1 drives out_*.
- Ready chain (combinational):
  - rdy[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - rdy[i] = !v[i] || rdy[i+1].
  - in_ready = rdy[0] && !flush.
- Stage update on clk when rdy[i] and not flush:
  - v[i] <= upstream valid, where the upstream valid for stage 0 is in_valid.
  - p[i] <= upstream payload only when the upstream valid is 1. Otherwise p[i] holds its value.
- When rdy[i] = 0 the stage holds both v[i] and p[i]. Full throughput: one request per cycle with no bubbles while out_ready = 1.
- Latency: a request accepted at edge k appears on out_* after edge k+DEPTH-1, i.e. out_valid rises DEPTH-1 cycles after the accepting edge (DEPTH=1 means visible the cycle after acceptance), provided no backpressure.
- Handshake rules:
  - A transfer occurs on a cycle where valid && ready.
  - Once out_valid = 1, out_* stay stable until out_ready.
  - The producer may drop in_valid at any time; no request is accepted without in_ready.
- Flush: all v[i] <= 0 at the next edge, no input is accepted that cycle, and occupancy <= 0. Payload registers are unchanged. Flush overrides a simultaneous input accept and output take; the output take still counts as consumed on the consumer side.
- Occupancy: a registered counter.
  - +1 on an input transfer; -1 on an output transfer; unchanged when both occur; 0 on flush.
  - Must always equal popcount(v). Never exceeds DEPTH and never underflows.
- chk_hit (combinational) = OR over i of (v[i] && p[i].rw && p[i].ena && p[i].addr == chk_addr). Invalid stages never hit. The input-side request is not checked.
- Full: when all v = 1 and out_ready = 0, in_ready = 0. When full and out_ready = 1, in_ready = 1 in the same cycle (pass-through accept).
- Reset mid-operation: asynchronous clear of all valid bits, payload and occupancy, with no partial transfer.

Decomposition:
- Shared package mem_req_pkg holds:
  - constant MEM_AW = 20;
  - constants RW_READ = 0 and RW_WRITE = 1;
  - packed struct typedef mem_req_t {addr, rw, ena, ipw}.
- One sub-module, mem_req_stage: a single valid/payload register with a load/hold enable and flush. mem_req_pipe instantiates it DEPTH times via generate and adds the ready chain, occupancy counter and hazard compare.

Test Plan:
- Reset with DEPTH=2: assert rst mid-stream -> out_valid=0, out_addr=0, occupancy=0, in_ready=1 immediately after reset.
- Streaming: requests at addresses 0x00010, 0x00011, 0x00012 on consecutive cycles, out_ready=1 -> same three appear in order back-to-back on consecutive cycles; occupancy peaks at 2.
- Backpressure: fill with 0x0A000 (write) and 0x0A004 (read), then hold out_ready=0 -> in_ready=0, out_addr=0x0A000 stable, occupancy=2. Release -> both drain in order with no loss or duplication.
- Flush: with 2 valid requests plus in_valid=1 and flush=1 -> next cycle out_valid=0, occupancy=0, and the presented input is not accepted.
- Hazard: write to 0x12345 in flight with chk_addr=0x12345 -> chk_hit=1. Change chk_addr to 0x12344, or issue a read to 0x12345 -> chk_hit=0. After the write drains, chk_hit=0.
- Full pass-through: pipe full and out_ready=1 with in_valid=1 -> in_ready=1, occupancy stays at 2, one in and one out per cycle for 10 cycles.
